// File: rtl/intr_ctrl_pkg.sv
// Purpose: shared constants for the interrupt controller (register map, FSM states, STATUS bits).
// Latency: n/a (constants only).
// Backpressure: n/a.
package intr_ctrl_pkg;

  // Register byte offsets from BASE
  localparam logic [31:0] OFF_PEND = 32'd0;
  localparam logic [31:0] OFF_EN   = 32'd4;
  localparam logic [31:0] OFF_STAT = 32'd8;
  localparam logic [31:0] OFF_EOI  = 32'd12;

  // Request/acknowledge/EOI handshake states
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  // STATUS register bit positions
  localparam int STAT_INSVC_BIT = 31;
  localparam int STAT_REQ_BIT   = 30;

endpackage

// File: rtl/prio_enc.sv
// Purpose: fixed-priority encoder; index of the lowest set request bit (bit 0 wins).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: req_i (NDEV request bits), idx_o (winning index, 0 when none), vld_o (any request set).
module prio_enc #(
  parameter int NDEV   = 4,
  parameter int IDBITS = 4
) (
  input  logic [NDEV-1:0]   req_i,
  output logic [IDBITS-1:0] idx_o,
  output logic              vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Scan from the top down so the lowest set bit is the last one to win
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDBITS'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Purpose: memory-mapped interrupt controller: sample, mask, prioritise, IRQ/IACK/EOI handshake.
// Latency: IRQ rises two edges after an enabled IRQ_IN line rises; register reads are combinational.
// Backpressure: none; bus accesses complete in one cycle, a new request waits for EOI while in service.
// Ports: CLK/RESET (async active-low); ABUS/DBUS/WE device bus; IRQ_IN device lines;
//        IACK processor acknowledge; IRQ request and IVEC source ID to the processor.
module intr_controller
  import intr_ctrl_pkg::*;
#(
  parameter int                 WBITS  = 32,
  parameter int                 NDEV   = 4,
  parameter int                 IDBITS = 4,
  parameter logic [WBITS-1:0]   BASE   = 32'hF000_0100
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WBITS-1:0]  ABUS,
  inout  wire  [WBITS-1:0]  DBUS,
  input  logic              WE,
  input  logic [NDEV-1:0]   IRQ_IN,
  input  logic              IACK,
  output logic              IRQ,
  output logic [IDBITS-1:0] IVEC
);

  logic [1:0]        state_q, state_d;
  logic              irq_q, irq_d;
  logic [IDBITS-1:0] ivec_q, ivec_d;
  logic [NDEV-1:0]   irq_in_q;
  logic [NDEV-1:0]   enable_q, enable_d;

  logic [NDEV-1:0]   pend;
  logic [IDBITS-1:0] win_idx;
  logic              pend_any;

  logic              hit_pend, hit_en, hit_stat, hit_eoi;
  logic              en_wr, eoi_wr;
  logic              rd_en;
  logic [WBITS-1:0]  rd_dat;
  logic              unused_dbus;

  assign pend = irq_in_q & enable_q;

  prio_enc #(
    .NDEV  (NDEV),
    .IDBITS(IDBITS)
  ) u_prio_enc (
    .req_i(pend),
    .idx_o(win_idx),
    .vld_o(pend_any)
  );

  // Bus decode
  assign hit_pend = (ABUS == BASE + WBITS'(OFF_PEND));
  assign hit_en   = (ABUS == BASE + WBITS'(OFF_EN));
  assign hit_stat = (ABUS == BASE + WBITS'(OFF_STAT));
  assign hit_eoi  = (ABUS == BASE + WBITS'(OFF_EOI));
  assign en_wr    = WE && hit_en;
  assign eoi_wr   = WE && hit_eoi;

  // Only the low NDEV bits of a write carry information
  assign unused_dbus = ^DBUS[WBITS-1:NDEV];

  assign enable_d = en_wr ? DBUS[NDEV-1:0] : enable_q;

  always_comb begin
    rd_en  = 1'b0;
    rd_dat = '0;
    if (!WE) begin
      if (hit_pend) begin
        rd_en  = 1'b1;
        rd_dat = WBITS'(pend);
      end else if (hit_en) begin
        rd_en  = 1'b1;
        rd_dat = WBITS'(enable_q);
      end else if (hit_stat) begin
        rd_en                  = 1'b1;
        rd_dat[STAT_INSVC_BIT] = (state_q == SERVICE);
        rd_dat[STAT_REQ_BIT]   = irq_q;
        rd_dat[IDBITS-1:0]     = ivec_q;
      end else if (hit_eoi) begin
        // Write-only register: drive zeros so the read still completes
        rd_en = 1'b1;
      end
    end
  end

  assign DBUS = rd_en ? rd_dat : {WBITS{1'bz}};

  // Handshake FSM; pend==0 in REQ takes precedence over a coincident IACK
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_any) state_d = REQ;
      REQ:     if (!pend_any) state_d = IDLE;
               else if (IACK) state_d = SERVICE;
      SERVICE: if (eoi_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IRQ and IVEC are registered from the next state so they line up with it.
  // On IACK the ID the processor just saw is frozen for the whole service.
  always_comb begin
    irq_d  = (state_d == REQ);
    ivec_d = '0;
    case (state_d)
      REQ:     ivec_d = win_idx;
      SERVICE: ivec_d = ivec_q;
      default: ivec_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      ivec_q   <= '0;
      irq_in_q <= '0;
      enable_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      ivec_q   <= ivec_d;
      irq_in_q <= IRQ_IN;
      enable_q <= enable_d;
    end
  end

  assign IRQ  = irq_q;
  assign IVEC = ivec_q;

endmodule

// File: tb/tb_intr_controller.sv
// Purpose: self-checking bench for intr_controller (vector table, directed sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_intr_controller;

  localparam logic [31:0] BASE  = 32'hF000_0100;
  localparam logic [31:0] A_PND = BASE + 32'd0;
  localparam logic [31:0] A_EN  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_EOI = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] abus = '0;
  wire  [31:0] dbus;
  logic        we = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        iack = 1'b0;
  logic        irq;
  logic [3:0]  ivec;
  logic        drv_en = 1'b0;
  logic [31:0] drv = '0;

  int n_cmp = 0;
  int n_err = 0;

  assign dbus = drv_en ? drv : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  intr_controller #(
    .WBITS(32), .NDEV(4), .IDBITS(4), .BASE(BASE)
  ) dut (
    .CLK(clk), .RESET(rst_n), .ABUS(abus), .DBUS(dbus), .WE(we),
    .IRQ_IN(irq_in), .IACK(iack), .IRQ(irq), .IVEC(ivec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    abus = a; we = 1'b1; drv = d; drv_en = 1'b1;
    tick();
    we = 1'b0; drv_en = 1'b0; abus = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    abus = a; we = 1'b0;
    #1;
    d = dbus;
    abus = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_iack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  // Reference: index of the lowest set bit, found by isolating it arithmetically
  function automatic logic [3:0] lsb(input logic [3:0] p);
    logic [3:0] iso;
    iso = p & (-p);
    return 4'($clog2(iso));
  endfunction

  typedef struct {
    logic [3:0] lines;
    logic [3:0] en;
    logic [3:0] exp_pend;
    logic       exp_irq;
    logic [3:0] exp_ivec;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] rd;
  // model state
  logic [3:0] samp_m, en_m, ivec_m, p;
  logic       svc_m, req_m, enw, eoiw;
  logic [31:0] wdat;
  int k;

  initial begin
    vecs[0] = '{4'b0001, 4'b1111, 4'b0001, 1'b1, 4'd0};
    vecs[1] = '{4'b1010, 4'b1111, 4'b1010, 1'b1, 4'd1};
    vecs[2] = '{4'b1100, 4'b1111, 4'b1100, 1'b1, 4'd2};
    vecs[3] = '{4'b1000, 4'b1111, 4'b1000, 1'b1, 4'd3};
    vecs[4] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[5] = '{4'b1111, 4'b1000, 4'b1000, 1'b1, 4'd3};
    vecs[6] = '{4'b0110, 4'b0100, 4'b0100, 1'b1, 4'd2};
    vecs[7] = '{4'b0101, 4'b1010, 4'b0000, 1'b0, 4'd0};
    vecs[8] = '{4'b1111, 4'b0110, 4'b0110, 1'b1, 4'd1};
    vecs[9] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 4'd0};

    // ---- reset with all lines high, nothing enabled
    irq_in = 4'b1111;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ivec", 32'(ivec), 32'd0);
    bus_rd(A_EN, rd); chk("rst_enable", rd, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_irq_disabled", 32'(irq), 32'd0);
    end
    bus_rd(A_PND, rd); chk("rst_pend_rd", rd, 32'd0);
    bus_rd(A_ST, rd);  chk("rst_stat_rd", rd, 32'd0);
    bus_rd(A_EOI, rd); chk("eoi_rd_zero", rd, 32'd0);

    // ---- priority / masking table (never acknowledged, so state is IDLE or REQ)
    for (int i = 0; i < 10; i++) begin
      irq_in = vecs[i].lines;
      bus_wr(A_EN, {28'hABCDEF0, vecs[i].en});
      tick();
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      chk($sformatf("tbl%0d_ivec", i), 32'(ivec), 32'(vecs[i].exp_ivec));
      bus_rd(A_PND, rd);
      chk($sformatf("tbl%0d_pend", i), rd, 32'(vecs[i].exp_pend));
      bus_rd(A_EN, rd);
      chk($sformatf("tbl%0d_en", i), rd, 32'(vecs[i].en));
    end
    irq_in = '0;
    do_reset();

    // ---- latency, IACK, EOI
    bus_wr(A_EN, 32'h4);
    irq_in = 4'b0100;                       // rises at edge k
    tick();                                 // k+1
    chk("lat_k1_irq", 32'(irq), 32'd0);
    tick();                                 // k+2
    chk("lat_k2_irq", 32'(irq), 32'd1);
    chk("lat_k2_ivec", 32'(ivec), 32'd2);
    bus_rd(A_ST, rd); chk("req_stat", rd, 32'h4000_0002);
    pulse_iack();
    chk("ack_irq", 32'(irq), 32'd0);
    chk("ack_ivec", 32'(ivec), 32'd2);
    bus_rd(A_ST, rd); chk("svc_stat", rd, 32'h8000_0002);
    irq_in = '0;
    tick();
    bus_wr(A_EOI, 32'h0);
    chk("eoi_irq", 32'(irq), 32'd0);
    bus_rd(A_ST, rd); chk("eoi_stat", rd, 32'd0);
    tick();
    bus_rd(A_ST, rd); chk("eoi_stat_hold", rd, 32'd0);

    // ---- no nesting; one idle cycle between services
    irq_in = 4'b1010;
    bus_wr(A_EN, 32'hF);
    tick();
    chk("prio_irq", 32'(irq), 32'd1);
    chk("prio_ivec", 32'(ivec), 32'd1);
    pulse_iack();
    bus_rd(A_ST, rd); chk("svc1_stat", rd, 32'h8000_0001);
    irq_in = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nonest_irq", 32'(irq), 32'd0);
      chk("nonest_ivec", 32'(ivec), 32'd1);
    end
    bus_wr(A_EOI, 32'h1);
    chk("gap_irq", 32'(irq), 32'd0);
    bus_rd(A_ST, rd); chk("gap_stat", rd, 32'd0);
    tick();
    chk("rereq_irq", 32'(irq), 32'd1);
    chk("rereq_ivec", 32'(ivec), 32'd0);

    // ---- disable while requesting; later IACK ignored
    bus_wr(A_EN, 32'h0);
    chk("dis_irq_same", 32'(irq), 32'd1);
    tick();
    chk("dis_irq_next", 32'(irq), 32'd0);
    pulse_iack();
    chk("late_ack_irq", 32'(irq), 32'd0);
    bus_rd(A_ST, rd); chk("late_ack_stat", rd, 32'd0);

    // ---- EOI in IDLE, IACK in SERVICE
    bus_wr(A_EOI, 32'h0);
    bus_rd(A_ST, rd); chk("idle_eoi_stat", rd, 32'd0);
    irq_in = 4'b0100;
    tick();
    bus_wr(A_EN, 32'hF);
    tick();
    chk("svc2_req_ivec", 32'(ivec), 32'd2);
    pulse_iack();
    bus_rd(A_ST, rd); chk("svc2_stat", rd, 32'h8000_0002);
    irq_in = 4'b0001;
    pulse_iack();
    tick();
    bus_rd(A_ST, rd); chk("svc_ack_ign_stat", rd, 32'h8000_0002);
    chk("svc_ack_ign_irq", 32'(irq), 32'd0);

    // ---- reset mid-service
    irq_in = 4'b0100;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_ivec", 32'(ivec), 32'd0);
    bus_rd(A_EN, rd); chk("midrst_en", rd, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postrst_irq", 32'(irq), 32'd0);
    end
    bus_wr(A_EN, 32'h4);
    tick();
    chk("reen_irq", 32'(irq), 32'd1);
    chk("reen_ivec", 32'(ivec), 32'd2);

    // ---- random traffic against the behavioural model
    irq_in = '0;
    do_reset();
    samp_m = '0; en_m = '0; ivec_m = '0; svc_m = 1'b0; req_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_irq", 32'(irq), 32'(req_m));
      chk("rnd_ivec", 32'(ivec), 32'(ivec_m));
      bus_rd(A_ST, rd);
      chk("rnd_stat", rd, {svc_m, req_m, 26'd0, ivec_m});
      bus_rd(A_PND, rd);
      chk("rnd_pend", rd, 32'(samp_m & en_m));

      if ($urandom_range(0, 4) == 0) irq_in = 4'($urandom);
      iack = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 9);
      wdat = $urandom;
      enw = (k < 2);
      eoiw = (k >= 2 && k < 4);
      if (enw || eoiw) begin
        abus = enw ? A_EN : A_EOI;
        we = 1'b1; drv = wdat; drv_en = 1'b1;
      end

      p = samp_m & en_m;
      if (svc_m) begin
        if (eoiw) begin svc_m = 1'b0; ivec_m = '0; end
      end else if (req_m) begin
        if (p == 0) begin req_m = 1'b0; ivec_m = '0; end
        else if (iack) begin req_m = 1'b0; svc_m = 1'b1; end
        else ivec_m = lsb(p);
      end else if (p != 0) begin
        req_m = 1'b1;
        ivec_m = lsb(p);
      end
      samp_m = irq_in;
      if (enw) en_m = wdat[3:0];

      tick();
      iack = 1'b0; we = 1'b0; drv_en = 1'b0; abus = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
